// File: rtl/lcd_sched_pkg.sv
// Shared types and defaults for the LCD vertical-blanking update scheduler.
package lcd_sched_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_VBLANK = 2'd2,
    ST_GRANT  = 2'd3
  } lcd_state_e;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_MAX_HOLD = 64;
  localparam int unsigned DEF_VB_GAP   = 1024;

  // Width of a counter that must be able to hold the value maxv.
  function automatic int unsigned cnt_w(input int unsigned maxv);
    return $clog2(maxv + 1);
  endfunction

  localparam int unsigned HOLD_W = $clog2(DEF_MAX_HOLD + 1);
  localparam int unsigned GAP_W  = $clog2(DEF_VB_GAP + 1);

endpackage

// File: rtl/lcd_vblank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo NUM_REQ. Usable by any shared LCD-side resource.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan from the farthest slot back to ptr_i so the closest request wins last.
  always_comb begin
    logic [IDX_W-1:0] j;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    j        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr_i) + k) % int'(NUM_REQ));
      if (req_i[j]) begin
        onehot_o    = '0;
        onehot_o[j] = 1'b1;
        idx_o       = j;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_vblank_arbiter.sv
// Tracks LCD lines/frames from data-enable and hands the vertical-blanking
// update window round-robin to game-logic requesters. Any grant still held
// when active video resumes is revoked on the same edge the window closes.
module lcd_vblank_arbiter
  import lcd_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned VB_GAP   = DEF_VB_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lcd_de,
  input  logic [10:0]        v_disp,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_abort,
  output logic               in_vblank,
  output logic               frame_tick,
  output logic               sync_err,
  output logic [15:0]        frame_cnt,
  output logic [10:0]        line_cnt
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned HCNT_W = cnt_w(MAX_HOLD);
  localparam int unsigned GCNT_W = cnt_w(VB_GAP);

  lcd_state_e          state_q, state_d;
  logic                de_q;
  logic [GCNT_W-1:0]   gap_q, gap_d;
  logic [HCNT_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                abort_q, abort_d;
  logic                tick_q, tick_d;
  logic                serr_q, serr_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic [10:0]         lcnt_q, lcnt_d;

  logic                rise, fall, gap_hit;
  logic [10:0]         lcnt_inc;
  logic [IDX_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  assign rise     = lcd_de & ~de_q;
  assign fall     = ~lcd_de & de_q;
  assign lcnt_inc = lcnt_q + 11'd1;

  // Pointer moves one past the requester that just finished, with wrap.
  assign ptr_next = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);

  // Blanking detector: run length of de-low cycles, saturating at VB_GAP.
  always_comb begin
    gap_d = gap_q;
    if (lcd_de)
      gap_d = '0;
    else if (gap_q != GCNT_W'(VB_GAP))
      gap_d = gap_q + GCNT_W'(1);
  end

  // Fires on the cycle the run reaches VB_GAP (or stays there).
  assign gap_hit = (gap_d == GCNT_W'(VB_GAP));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Frame tracking and window arbitration: next state and registered outputs.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    abort_d = 1'b0;
    tick_d  = 1'b0;
    serr_d  = 1'b0;
    fcnt_d  = fcnt_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      ST_SYNC: begin
        // Lines before the first full blanking gap are not trusted.
        if (gap_hit) state_d = ST_VBLANK;
      end
      ST_ACTIVE: begin
        if (fall) begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == v_disp) begin
            tick_d  = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            lcnt_d  = '0;
            state_d = ST_VBLANK;
          end
        end else if (gap_hit) begin
          // Blanking showed up early: realign on it and still open the window.
          serr_d  = 1'b1;
          lcnt_d  = '0;
          state_d = ST_VBLANK;
        end
      end
      ST_VBLANK: begin
        if (rise) begin
          state_d = ST_ACTIVE;
        end else if (pick_any) begin
          state_d = ST_GRANT;
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          hold_d  = HCNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (rise) begin
          gnt_d   = '0;
          abort_d = 1'b1;
          ptr_d   = ptr_next;
          state_d = ST_ACTIVE;
        end else if (!req[win_q] || hold_q == HCNT_W'(MAX_HOLD)) begin
          // Release or forced release; always passes through one idle cycle.
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = ST_VBLANK;
        end else begin
          hold_d = hold_q + HCNT_W'(1);
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      de_q    <= 1'b0;
      gap_q   <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      abort_q <= 1'b0;
      tick_q  <= 1'b0;
      serr_q  <= 1'b0;
      fcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= lcd_de;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      abort_q <= abort_d;
      tick_q  <= tick_d;
      serr_q  <= serr_d;
      fcnt_q  <= fcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_abort  = abort_q;
  assign in_vblank  = (state_q == ST_VBLANK) || (state_q == ST_GRANT);
  assign frame_tick = tick_q;
  assign sync_err   = serr_q;
  assign frame_cnt  = fcnt_q;
  assign line_cnt   = lcnt_q;

  // Grant safety: never more than one holder, never outside the window.
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_in_win: assert property (@(posedge clk) disable iff (!rst_n) (|gnt) |-> in_vblank);

endmodule

// File: tb/tb_lcd_vblank_arbiter.sv
// Randomised bench for lcd_vblank_arbiter against a frame/window model.
module tb_lcd_vblank_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;
  localparam int VG = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lcd_de = 1'b0;
  logic [10:0]   v_disp = 11'd4;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic          gnt_abort, in_vblank, frame_tick, sync_err;
  logic [15:0]   frame_cnt;
  logic [10:0]   line_cnt;

  lcd_vblank_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH), .VB_GAP(VG)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_de(lcd_de), .v_disp(v_disp), .req(req),
    .gnt(gnt), .gnt_abort(gnt_abort), .in_vblank(in_vblank),
    .frame_tick(frame_tick), .sync_err(sync_err),
    .frame_cnt(frame_cnt), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit rnd_req = 1'b0;
  int tick_seen = 0, g2_cnt = 0;
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] gq[$];

  // model: window open/closed, who holds it, and how long
  bit m_synced, m_win, m_de_prev, m_tick, m_abort, m_err;
  int m_low, m_lines, m_frames, m_holder, m_held, m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_synced = 0; m_win = 0; m_de_prev = 0; m_tick = 0; m_abort = 0; m_err = 0;
    m_low = 0; m_lines = 0; m_frames = 0; m_holder = -1; m_held = 0; m_ptr = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic m_step();
    bit rise, fall, blank;
    int w;
    rise = lcd_de && !m_de_prev;
    fall = !lcd_de && m_de_prev;
    m_de_prev = lcd_de;
    m_low = lcd_de ? 0 : ((m_low < VG) ? m_low + 1 : VG);
    blank = (m_low >= VG);
    m_tick = 0; m_abort = 0; m_err = 0;
    if (!m_synced) begin
      if (blank) begin m_synced = 1; m_win = 1; end
    end else if (!m_win) begin
      if (fall) begin
        m_lines = (m_lines + 1) & 'h7FF;
        if (m_lines == int'(v_disp)) begin
          m_tick = 1; m_frames = (m_frames + 1) & 'hFFFF; m_lines = 0; m_win = 1;
        end
      end else if (blank) begin
        m_err = 1; m_lines = 0; m_win = 1;
      end
    end else if (m_holder < 0) begin
      if (rise) m_win = 0;
      else begin
        w = pick(req, m_ptr);
        if (w >= 0) begin m_holder = w; m_held = 1; end
      end
    end else begin
      if (rise) begin
        m_abort = 1; m_win = 0; m_ptr = (m_holder + 1) % N; m_holder = -1;
      end else if (!req[m_holder] || m_held == MH) begin
        m_ptr = (m_holder + 1) % N; m_holder = -1;
      end else m_held++;
    end
  endtask

  task automatic compare_all();
    chk("gnt", 32'(gnt), (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
    chk("in_vblank", 32'(in_vblank), 32'(m_win));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("gnt_abort", 32'(gnt_abort), 32'(m_abort));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    chk("line_cnt", 32'(line_cnt), 32'(m_lines));
  endtask

  task automatic tick();
    if (rnd_req)
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
    @(posedge clk);
    if (rst_n) m_step();
    #1;
    compare_all();
    if (frame_tick) tick_seen++;
    if (gnt[2]) g2_cnt++;
    if (gnt != '0 && prev_gnt == '0) gq.push_back(gnt);
    prev_gnt = gnt;
  endtask

  task automatic line(input int hi, input int lo);
    lcd_de = 1'b1; repeat (hi) tick();
    lcd_de = 1'b0; repeat (lo) tick();
  endtask

  task automatic frame(input int nl, input int gap);
    for (int i = 0; i < nl - 1; i++) line($urandom_range(10, 4), $urandom_range(6, 2));
    line($urandom_range(10, 4), gap);
  endtask

  logic [N-1:0] exp_rr [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

  initial begin
    m_reset();
    #12;
    compare_all();
    chk("rst_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first frame: unsynchronised, window opens after exactly VG low cycles
    repeat (3) line(8, 4);
    lcd_de = 1'b1; repeat (8) tick();
    lcd_de = 1'b0; repeat (VG - 1) tick();
    chk("sync_vb_early", 32'(in_vblank), 32'd0);
    tick();
    chk("sync_vb_open", 32'(in_vblank), 32'd1);
    repeat (40 - VG) tick();
    chk("sync_no_tick", 32'(tick_seen), 32'd0);
    frame(4, 40);
    chk("f2_ticks", 32'(tick_seen), 32'd1);
    chk("f2_frame_cnt", 32'(frame_cnt), 32'd1);

    // round robin with a held request set, exactly filling the window
    req = 4'b1011;
    gq.delete();
    frame(4, 28);
    frame(4, 28);
    req = '0;
    chk("rr_n", 32'(gq.size()), 32'd6);
    for (int k = 0; k < 4; k++)
      chk("rr_order", (gq.size() > k) ? 32'(gq[k]) : 32'hDEAD, 32'(exp_rr[k]));

    // voluntary release after three cycles, pointer then favours requester 3
    repeat (3) line(8, 4);
    lcd_de = 1'b1; repeat (6) tick();
    lcd_de = 1'b0; tick();
    g2_cnt = 0;
    req = 4'b0100; repeat (3) tick();
    chk("rel_hold", 32'(gnt), 32'h4);
    req = '0; tick();
    chk("rel_drop", 32'(gnt), 32'h0);
    req = 4'b1111; tick();
    chk("rel_ptr", 32'(gnt), 32'h8);
    req = '0; repeat (14) tick();
    chk("rel_len", 32'(g2_cnt), 32'd3);

    // abort: video restarts during a grant
    repeat (3) line(8, 4);
    lcd_de = 1'b1; repeat (6) tick();
    lcd_de = 1'b0; req = 4'b0001; repeat (12) tick();
    lcd_de = 1'b1; tick();
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_pulse", 32'(gnt_abort), 32'd1);
    chk("abort_vb", 32'(in_vblank), 32'd0);
    repeat (5) tick();
    req = '0;
    lcd_de = 1'b0; repeat (3) tick();
    frame(3, 40);

    // sync error: only two lines before the gap
    line(8, 4);
    lcd_de = 1'b1; repeat (8) tick();
    lcd_de = 1'b0; repeat (VG) tick();
    chk("serr_pulse", 32'(sync_err), 32'd1);
    chk("serr_lines", 32'(line_cnt), 32'd0);
    chk("serr_vb", 32'(in_vblank), 32'd1);
    repeat (24) tick();

    // reset while requester 2 holds the window
    repeat (3) line(8, 4);
    lcd_de = 1'b1; repeat (8) tick();
    lcd_de = 1'b0; req = 4'b0100; repeat (3) tick();
    chk("pre_rst_gnt", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    m_reset();
    req = '0; repeat (3) tick();
    v_disp = 11'd3;
    rst_n = 1'b1;

    // random requests, occasional short frames
    rnd_req = 1'b1;
    frame(3, 40);
    repeat (40) frame(($urandom_range(9) == 0) ? 1 : 3, $urandom_range(60, 20));
    rnd_req = 1'b0;
    req = '0;

    // v_disp = 0: every frame resynchronises through sync_err
    #2 rst_n = 1'b0;
    #1 m_reset();
    repeat (2) tick();
    v_disp = 11'd0;
    rst_n = 1'b1;
    rnd_req = 1'b1;
    repeat (4) frame(3, 30);
    rnd_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
